// File: rtl/cb_segmenter_if.sv
// Stream bundle around the code-block segmenter.
//   desc_*   : descriptor FIFO side (normal-mode FIFO, q valid the cycle after rd)
//   in_*     : bit-serial transport-block payload, valid/ready handshake
//   out_*    : bit-serial code-block stream with per-bit framing flags
//   busy     : transport block in progress
//   desc_err : one-cycle pulse on an illegal descriptor
// Modport master is the environment (FIFO, payload source, downstream sink);
// modport slave is the segmenter itself.
interface cb_segmenter_if;
  logic        desc_empty;
  logic        desc_rd;
  logic [19:0] desc_q;
  logic        in_bit;
  logic        in_valid;
  logic        in_ready;
  logic        out_bit;
  logic        out_valid;
  logic        out_ready;
  logic        out_sob;
  logic        out_eob;
  logic        out_filler;
  logic        out_kplus;
  logic        busy;
  logic        desc_err;

  modport master (
    output desc_empty, desc_q, in_bit, in_valid, out_ready,
    input  desc_rd, in_ready, out_bit, out_valid, out_sob, out_eob,
           out_filler, out_kplus, busy, desc_err
  );

  modport slave (
    input  desc_empty, desc_q, in_bit, in_valid, out_ready,
    output desc_rd, in_ready, out_bit, out_valid, out_sob, out_eob,
           out_filler, out_kplus, busy, desc_err
  );
endinterface

// File: rtl/cb_segmenter.sv
// Code-block segmenter. Pops one {C_plus, C_minus, filler} descriptor per
// transport block, then streams the code blocks bit-serially: filler bits
// (block 0 only), payload bits passed straight through, and a CRC24B trailer
// per block when the transport block splits into two code blocks.
// Ports:
//   clk  : clock
//   aclr : asynchronous reset, active-high
//   seg  : cb_segmenter_if.slave (descriptor FIFO, payload in, block stream out)
module cb_segmenter #(
  parameter int          K_PLUS   = 6144,
  parameter int          K_MINUS  = 1056,
  parameter int          L_CRC    = 24,
  parameter logic [23:0] CRC_POLY = 24'h800063,
  parameter int          CNT_W    = 13
) (
  input  logic           clk,
  input  logic           aclr,
  cb_segmenter_if.slave  seg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_FILL  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_CRC   = 3'd5;

  localparam logic [CNT_W-1:0] KP       = CNT_W'(K_PLUS);
  localparam logic [CNT_W-1:0] KM       = CNT_W'(K_MINUS);
  localparam logic [CNT_W-1:0] LC       = CNT_W'(L_CRC);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(L_CRC - 1);
  // Block 1 only exists in the two-block plans, and is always K_PLUS with CRC.
  localparam logic [CNT_W-1:0] D1_LAST  = CNT_W'(K_PLUS - L_CRC - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] data0_q;
  logic [23:0]      crc;
  logic             blk;
  logic             two_blk;
  logic             kplus0;
  logic             sob_pend;
  logic             err_q;

  // MSB-first CRC24B LFSR step, x^24 implicit.
  function automatic logic [23:0] crc_step(input logic [23:0] c, input logic b);
    logic fb;
    fb = c[23] ^ b;
    return {c[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h0);
  endfunction

  // Descriptor decode, only meaningful while in LOAD.
  logic [1:0]       cp;
  logic [1:0]       cm;
  logic [15:0]      fill_raw;
  logic [CNT_W-1:0] fill_n;
  logic [CNT_W-1:0] k0;
  logic [CNT_W-1:0] crc_len;
  logic [CNT_W-1:0] data0;
  logic             code_ok;
  logic             dec_two;
  logic             dec_kplus0;
  logic             bad;

  always_comb begin
    cp         = seg.desc_q[19:18];
    cm         = seg.desc_q[17:16];
    fill_raw   = seg.desc_q[15:0];
    code_ok    = 1'b1;
    dec_two    = 1'b0;
    dec_kplus0 = 1'b1;
    case ({cp, cm})
      4'b10_00: dec_two = 1'b1;
      4'b01_01: begin
        dec_two    = 1'b1;
        dec_kplus0 = 1'b0;
      end
      4'b01_00: dec_kplus0 = 1'b1;
      4'b00_01: dec_kplus0 = 1'b0;
      default:  code_ok = 1'b0;
    endcase
    k0      = dec_kplus0 ? KP : KM;
    crc_len = dec_two ? LC : '0;
    fill_n  = fill_raw[CNT_W-1:0];
    // Filler must leave at least one data bit in block 0.
    bad     = !code_ok || (|fill_raw[15:CNT_W]) || (fill_n >= k0 - crc_len);
    data0   = k0 - crc_len - fill_n;
  end

  logic s_fill;
  logic s_data;
  logic s_crc;
  logic xfer;

  always_comb begin
    s_fill = (state == S_FILL);
    s_data = (state == S_DATA);
    s_crc  = (state == S_CRC);
    xfer   = seg.out_ready & (s_fill | s_crc | (s_data & seg.in_valid));

    seg.desc_rd    = (state == S_FETCH);
    seg.in_ready   = s_data & seg.out_ready;
    seg.out_valid  = s_fill | s_crc | (s_data & seg.in_valid);
    seg.out_bit    = s_data ? seg.in_bit : (s_crc ? crc[cnt[4:0]] : 1'b0);
    seg.out_filler = s_fill;
    seg.out_sob    = sob_pend & seg.out_valid;
    seg.out_eob    = (s_data & seg.in_valid & (cnt == '0) & !two_blk) |
                     (s_crc & (cnt == '0));
    seg.out_kplus  = (s_fill | s_data | s_crc) & (blk | kplus0);
    seg.busy       = s_fill | s_data | s_crc | (state == S_LOAD);
    seg.desc_err   = err_q;
  end

  // Control and block state; everything advances only on a transfer so that
  // backpressure freezes the whole datapath.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state    <= S_IDLE;
      cnt      <= '0;
      data0_q  <= '0;
      crc      <= '0;
      blk      <= 1'b0;
      two_blk  <= 1'b0;
      kplus0   <= 1'b0;
      sob_pend <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!seg.desc_empty) state <= S_FETCH;
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          if (bad) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            two_blk  <= dec_two;
            kplus0   <= dec_kplus0;
            blk      <= 1'b0;
            crc      <= '0;
            sob_pend <= 1'b1;
            data0_q  <= data0;
            if (fill_n != '0) begin
              state <= S_FILL;
              cnt   <= fill_n - ONE;
            end else begin
              state <= S_DATA;
              cnt   <= data0 - ONE;
            end
          end
        end
        S_FILL: begin
          if (xfer) begin
            crc      <= crc_step(crc, 1'b0);
            sob_pend <= 1'b0;
            if (cnt == '0) begin
              state <= S_DATA;
              cnt   <= data0_q - ONE;
            end else begin
              cnt <= cnt - ONE;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            crc      <= crc_step(crc, seg.in_bit);
            sob_pend <= 1'b0;
            if (cnt == '0) begin
              if (two_blk) begin
                state <= S_CRC;
                cnt   <= CRC_LAST;
              end else begin
                // Single block done: allow the next fetch immediately.
                state <= seg.desc_empty ? S_IDLE : S_FETCH;
              end
            end else begin
              cnt <= cnt - ONE;
            end
          end
        end
        S_CRC: begin
          if (xfer) begin
            sob_pend <= 1'b0;
            if (cnt == '0) begin
              if (!blk) begin
                state    <= S_DATA;
                blk      <= 1'b1;
                cnt      <= D1_LAST;
                crc      <= '0;
                sob_pend <= 1'b1;
              end else begin
                state <= seg.desc_empty ? S_IDLE : S_FETCH;
              end
            end else begin
              cnt <= cnt - ONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cb_segmenter.sv
// Self-checking bench for cb_segmenter: descriptor FIFO model, payload source
// with optional random stalls, and a scoreboard of expected output bits.
module tb_cb_segmenter;

  localparam logic [23:0] POLY = 24'h800063;

  logic clk;
  logic aclr;

  cb_segmenter_if sif ();

  cb_segmenter dut (
    .clk  (clk),
    .aclr (aclr),
    .seg  (sif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected record: {bit, filler, sob, eob, kplus}
  logic [4:0]  exp_q[$];
  logic        pay_q[$];
  logic [19:0] desc_fifo[$];
  logic        pl_stage[$];
  logic        saved_pl[$];
  logic        msg_q[$];
  logic [23:0] tails[$];

  int stall_pct = 0;
  bit in_acc    = 0;
  bit rd_seen   = 0;

  int n_out, sob_cnt, eob_cnt, rd_cnt, err_cnt, stall_seen;
  int cyc = 0, fall_cyc = 0, rd_cyc = 0;

  // Reference CRC by polynomial long division of msg_q * x^24.
  function automatic logic [23:0] crc_div();
    logic [24:0] r;
    r = '0;
    for (int i = 0; i < msg_q.size() + 24; i++) begin
      r = {r[23:0], (i < msg_q.size()) ? msg_q[i] : 1'b0};
      if (r[24]) r = r ^ {1'b1, POLY};
    end
    return r[23:0];
  endfunction

  // Build the expected stream for one descriptor using pl_stage as payload.
  task automatic enqueue(input logic [1:0] cp, input logic [1:0] cm, input int fill);
    int   nblk, f, nd, idx;
    int   k[2];
    bit   crc_on;
    logic kp;
    logic [23:0] c;
    case ({cp, cm})
      4'b10_00: begin nblk = 2; k[0] = 6144; k[1] = 6144; end
      4'b01_01: begin nblk = 2; k[0] = 1056; k[1] = 6144; end
      4'b01_00: begin nblk = 1; k[0] = 6144; k[1] = 0; end
      default:  begin nblk = 1; k[0] = 1056; k[1] = 0; end
    endcase
    crc_on = (nblk == 2);
    idx = 0;
    for (int b = 0; b < nblk; b++) begin
      msg_q.delete();
      f  = (b == 0) ? fill : 0;
      nd = k[b] - (crc_on ? 24 : 0) - f;
      kp = (k[b] == 6144);
      for (int i = 0; i < f; i++) begin
        exp_q.push_back({1'b0, 1'b1, (i == 0), 1'b0, kp});
        msg_q.push_back(1'b0);
      end
      for (int i = 0; i < nd; i++) begin
        exp_q.push_back({pl_stage[idx], 1'b0, (f == 0 && i == 0), (!crc_on && i == nd - 1), kp});
        msg_q.push_back(pl_stage[idx]);
        idx++;
      end
      if (crc_on) begin
        c = crc_div();
        for (int i = 0; i < 24; i++) exp_q.push_back({c[23-i], 1'b0, 1'b0, (i == 23), kp});
      end
    end
    foreach (pl_stage[i]) pay_q.push_back(pl_stage[i]);
    desc_fifo.push_back({cp, cm, 16'(fill)});
  endtask

  function automatic logic [9:0] out_vec();
    return {sif.desc_rd, sif.in_ready, sif.out_valid, sif.out_bit, sif.out_sob,
            sif.out_eob, sif.out_filler, sif.out_kplus, sif.busy, sif.desc_err};
  endfunction

  // Environment driver: descriptor FIFO, payload source, downstream ready.
  initial begin
    sif.desc_empty = 1'b1;
    sif.desc_q     = '0;
    sif.in_bit     = 1'b0;
    sif.in_valid   = 1'b0;
    sif.out_ready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (aclr) begin
        sif.in_valid  = 1'b0;
        sif.in_bit    = 1'b0;
        sif.out_ready = 1'b0;
      end else begin
        if (rd_seen && desc_fifo.size() > 0) sif.desc_q = desc_fifo.pop_front();
        if (in_acc && pay_q.size() > 0) void'(pay_q.pop_front());
        if (!(sif.in_valid && !in_acc)) begin
          if (pay_q.size() > 0 && int'($urandom_range(99)) >= stall_pct) begin
            sif.in_valid = 1'b1;
            sif.in_bit   = pay_q[0];
          end else begin
            sif.in_valid = 1'b0;
          end
        end
        sif.out_ready = (int'($urandom_range(99)) >= stall_pct);
      end
      sif.desc_empty = (desc_fifo.size() == 0);
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  initial begin
    logic [5:0]  prev_vec, cur_vec;
    logic [23:0] sh;
    bit          prev_stall, prev_empty;
    logic [4:0]  e;
    prev_stall = 0;
    prev_empty = 1;
    sh = '0;
    forever begin
      @(negedge clk);
      cyc++;
      cur_vec = {sif.out_valid, sif.out_bit, sif.out_sob, sif.out_eob, sif.out_filler, sif.out_kplus};
      if (aclr) begin
        in_acc     = 0;
        rd_seen    = 0;
        prev_stall = 0;
      end else begin
        if (prev_stall) chk("hold_out", 32'(cur_vec), 32'(prev_vec));
        prev_stall = sif.out_valid && !sif.out_ready;
        if (prev_stall) stall_seen++;
        prev_vec = cur_vec;
        in_acc   = sif.in_valid && sif.in_ready;
        rd_seen  = sif.desc_rd;
        if (prev_empty && !sif.desc_empty) fall_cyc = cyc;
        if (sif.desc_rd) begin rd_cyc = cyc; rd_cnt++; end
        if (sif.desc_err) err_cnt++;
        if (sif.out_valid && sif.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_extra_bit", 32'(1), 32'(0));
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("sb[%0d]", n_out),
                32'({sif.out_bit, sif.out_filler, sif.out_sob, sif.out_eob, sif.out_kplus}), 32'(e));
          end
          n_out++;
          if (sif.out_sob) sob_cnt++;
          sh = {sh[22:0], sif.out_bit};
          if (sif.out_eob) begin eob_cnt++; tails.push_back(sh); end
        end
      end
      prev_empty = sif.desc_empty;
    end
  end

  task automatic clear_stats();
    n_out = 0; sob_cnt = 0; eob_cnt = 0; rd_cnt = 0; err_cnt = 0; stall_seen = 0;
    tails.delete();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_time"}, 32'(n < budget), 32'(1));
    repeat (4) @(negedge clk);
    chk({tag, "_busy_end"}, 32'(sif.busy), 32'(0));
    chk({tag, "_payload_left"}, 32'(pay_q.size()), 32'(0));
  endtask

  task automatic rand_payload(input int n);
    pl_stage.delete();
    for (int i = 0; i < n; i++) pl_stage.push_back($urandom_range(1) == 1);
  endtask

  initial begin
    int n;
    aclr = 1'b1;
    clear_stats();
    repeat (3) @(posedge clk);
    #3;
    chk("reset_outputs", 32'(out_vec()), 32'(0));
    @(posedge clk);
    #2 aclr = 1'b0;

    // 1: single K_MINUS block, 1016 filler + 40 data, no CRC
    clear_stats();
    rand_payload(40);
    enqueue(2'd0, 2'd1, 1016);
    wait_done("t1", 3000);
    chk("t1_rd_latency", 32'(rd_cyc - fall_cyc), 32'(1));
    chk("t1_rd_count", 32'(rd_cnt), 32'(1));
    chk("t1_total", 32'(n_out), 32'(1056));
    chk("t1_sob", 32'(sob_cnt), 32'(1));
    chk("t1_eob", 32'(eob_cnt), 32'(1));

    // 2: two K_PLUS blocks, all-zero payload
    clear_stats();
    pl_stage.delete();
    for (int i = 0; i < 12240; i++) pl_stage.push_back(1'b0);
    enqueue(2'd2, 2'd0, 0);
    wait_done("t2", 14000);
    chk("t2_total", 32'(n_out), 32'(12288));
    chk("t2_sob", 32'(sob_cnt), 32'(2));
    chk("t2_eob", 32'(eob_cnt), 32'(2));

    // 3: K_MINUS + K_PLUS with filler, random payload
    clear_stats();
    rand_payload(7000);
    saved_pl = pl_stage;
    enqueue(2'd1, 2'd1, 152);
    wait_done("t3", 9000);
    chk("t3_total", 32'(n_out), 32'(7200));
    chk("t3_eob", 32'(eob_cnt), 32'(2));

    // 4: CRC of a single trailing 1 equals the generator polynomial
    clear_stats();
    pl_stage.delete();
    for (int i = 0; i < 12240; i++) pl_stage.push_back((i == 6119) ? 1'b1 : (i >= 6120 && $urandom_range(1) == 1));
    enqueue(2'd2, 2'd0, 0);
    wait_done("t4", 14000);
    chk("t4_tails", 32'(tails.size()), 32'(2));
    if (tails.size() > 0) chk("t4_crc_blk0", 32'(tails[0]), 32'(24'h800063));

    // 5: same stream as test 3 under random stalls on both sides
    clear_stats();
    stall_pct = 35;
    pl_stage = saved_pl;
    enqueue(2'd1, 2'd1, 152);
    wait_done("t5", 40000);
    stall_pct = 0;
    chk("t5_total", 32'(n_out), 32'(7200));
    chk("t5_stalls_seen", 32'(stall_seen > 0), 32'(1));

    // 6: illegal descriptors, then a legal one
    clear_stats();
    desc_fifo.push_back({2'd3, 2'd0, 16'd5});
    desc_fifo.push_back({2'd1, 2'd1, 16'd1032});
    desc_fifo.push_back({2'd1, 2'd0, 16'h2000});
    rand_payload(1056);
    enqueue(2'd0, 2'd1, 0);
    wait_done("t6", 3000);
    chk("t6_err_pulses", 32'(err_cnt), 32'(3));
    chk("t6_total", 32'(n_out), 32'(1056));

    // 7: reset in the middle of DATA, then a clean descriptor
    clear_stats();
    rand_payload(6144);
    enqueue(2'd1, 2'd0, 0);
    n = 0;
    while (n_out < 500 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t7_reached_data", 32'(n_out >= 500), 32'(1));
    @(posedge clk);
    #2 aclr = 1'b1;
    #1;
    chk("t7_reset_outputs", 32'(out_vec()), 32'(0));
    exp_q.delete(); pay_q.delete(); desc_fifo.delete();
    repeat (2) @(posedge clk);
    #2;
    exp_q.delete(); pay_q.delete(); desc_fifo.delete();
    aclr = 1'b0;
    clear_stats();
    rand_payload(40);
    enqueue(2'd0, 2'd1, 1016);
    wait_done("t7", 3000);
    chk("t7_total", 32'(n_out), 32'(1056));
    chk("t7_rd_count", 32'(rd_cnt), 32'(1));
    chk("t7_eob", 32'(eob_cnt), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
